// File: rtl/instruction_fetch_controller_pkg.sv
// Shared widths, FSM encoding and prefetch entry layout for the RICS instruction fetch path.
package instruction_fetch_controller_pkg;

   localparam int INSTR_W        = 16;
   localparam int ADDR_W         = 16;
   localparam int LINE_W         = 64;
   localparam int WORDS_PER_LINE = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(7);
   endfunction

endpackage

// File: rtl/instruction_fetch_controller_fetch_fifo.sv
// Circular prefetch buffer of {pc,instr}: up to four parallel pushes and one pop per cycle.
// Head is visible the cycle after the push; sync flush empties it; callers guarantee room.
module instruction_fetch_controller_fetch_fifo
   import instruction_fetch_controller_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic [2:0]                            push_cnt,
   input  fetch_entry_t [WORDS_PER_LINE-1:0]     push_data,
   input  logic                                  pop,
   output fetch_entry_t                          head,
   output logic                                  empty,
   output logic [CW-1:0]                         count
);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   fetch_entry_t  mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         wr_ptr <= wr_ptr + AW'(push_cnt);
         count  <= count + CW'(push_cnt) - CW'(pop);
      end
   end

   // Storage carries no reset; the head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (i < int'(push_cnt)) mem[wr_ptr + AW'(i)] <= push_data[i];
         end
      end
   end

   assign empty = (count == '0);
   assign head  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst_n && !flush) begin
         assert (!(pop && empty));
         assert (({1'b0, count} + (CW+1)'(push_cnt) - (CW+1)'(pop)) <= (CW+1)'(DEPTH));
      end
   end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer: issues line addresses, splits returned lines into a prefetch FIFO feeding decode.
// First instruction appears 3+ cycles after REQ; decode stalls via inp_instr_ready, fetch idles when full.
module instruction_fetch_controller
   import instruction_fetch_controller_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 16'd256,
   parameter int                FIFO_DEPTH = 8
) (
   input  logic                inp_clk,
   input  logic                inp_rst_n,
   output logic [ADDR_W-1:0]   out_mem_address,
   input  logic                inp_mem_valid,
   input  logic [LINE_W-1:0]   inp_mem_dataLine,
   input  logic                inp_branch_valid,
   input  logic [ADDR_W-1:0]   inp_branch_target,
   output logic                out_instr_valid,
   input  logic                inp_instr_ready,
   output logic [INSTR_W-1:0]  out_instr,
   output logic [ADDR_W-1:0]   out_pc,
   output logic                out_busy
);

   localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] LINE_C  = CW'(WORDS_PER_LINE);

   fetch_state_t                       state, next_state;
   logic [ADDR_W-1:0]                  fetch_pc, fetch_pc_next;
   logic [ADDR_W-1:0]                  mem_addr, line_addr;
   logic                               busy_q;
   logic [1:0]                         skip, idx;
   logic                               capture, pop, fifo_empty;
   logic [2:0]                         push_cnt;
   fetch_entry_t [WORDS_PER_LINE-1:0]  push_data;
   fetch_entry_t                       head;
   logic [CW-1:0]                      count, free_now, free_after;

   assign skip      = fetch_pc[2:1];
   assign line_addr = line_of(fetch_pc);

   // A redirect cancels both the pop and any line captured in the same cycle.
   assign pop        = !fifo_empty && inp_instr_ready && !inp_branch_valid;
   assign capture    = (state == S_WAIT) && inp_mem_valid && !inp_branch_valid;
   assign push_cnt   = capture ? (3'd4 - {1'b0, skip}) : 3'd0;
   assign free_now   = DEPTH_C - (count - CW'(pop));
   assign free_after = free_now - CW'(push_cnt);

   always_comb begin
      push_data = '0;
      idx       = '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         idx                = skip + 2'(i);
         push_data[i].pc    = line_addr + ADDR_W'({idx, 1'b0});
         push_data[i].instr = inp_mem_dataLine[{idx, 4'b0000} +: INSTR_W];
      end
   end

   always_ff @(posedge inp_clk or negedge inp_rst_n) begin
      if (!inp_rst_n) begin
         state    <= S_REQ;
         fetch_pc <= RESET_PC;
         mem_addr <= line_of(RESET_PC);
         busy_q   <= 1'b0;
      end else begin
         state    <= next_state;
         fetch_pc <= fetch_pc_next;
         if (next_state == S_REQ) mem_addr <= line_of(fetch_pc_next);
         busy_q   <= (next_state != S_IDLE);
      end
   end

   always_comb begin
      next_state    = state;
      fetch_pc_next = fetch_pc;
      if (inp_branch_valid) begin
         next_state    = S_REQ;
         fetch_pc_next = inp_branch_target & ~ADDR_W'(1);
      end else begin
         case (state)
            S_IDLE: if (free_now >= (LINE_C - CW'(skip))) next_state = S_REQ;
            S_REQ:  next_state = S_WAIT;
            S_WAIT: begin
               if (capture) begin
                  fetch_pc_next = line_addr + ADDR_W'(8);
                  next_state    = (free_after >= LINE_C) ? S_REQ : S_IDLE;
               end
            end
            default: next_state = S_REQ;
         endcase
      end
   end

   always_comb begin
      out_mem_address = mem_addr;
      out_busy        = busy_q;
      out_instr_valid = !fifo_empty;
      out_instr       = head.instr;
      out_pc          = head.pc;
   end

   instruction_fetch_controller_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (inp_clk),
      .rst_n     (inp_rst_n),
      .flush     (inp_branch_valid),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .count     (count)
   );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench: memory model with 2-cycle response, scoreboard of expected PCs checked on every pop.
module tb_instruction_fetch_controller;

   logic        inp_clk = 1'b0;
   logic        inp_rst_n = 1'b0;
   logic [15:0] out_mem_address;
   logic        inp_mem_valid = 1'b0;
   logic [63:0] inp_mem_dataLine = '0;
   logic        inp_branch_valid = 1'b0;
   logic [15:0] inp_branch_target = '0;
   logic        out_instr_valid;
   logic        inp_instr_ready = 1'b0;
   logic [15:0] out_instr;
   logic [15:0] out_pc;
   logic        out_busy;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          pops = 0;
   logic [15:0] sb[$];
   logic [15:0] mon_pc;
   logic [15:0] mem_last = 16'hFFFF;
   int          mem_age = 0;

   instruction_fetch_controller dut (
      .inp_clk           (inp_clk),
      .inp_rst_n         (inp_rst_n),
      .out_mem_address   (out_mem_address),
      .inp_mem_valid     (inp_mem_valid),
      .inp_mem_dataLine  (inp_mem_dataLine),
      .inp_branch_valid  (inp_branch_valid),
      .inp_branch_target (inp_branch_target),
      .out_instr_valid   (out_instr_valid),
      .inp_instr_ready   (inp_instr_ready),
      .out_instr         (out_instr),
      .out_pc            (out_pc),
      .out_busy          (out_busy)
   );

   always #5 inp_clk = ~inp_clk;

   function automatic logic [15:0] instr_of(input logic [15:0] pc);
      return {pc[7:0], pc[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge inp_clk);
      #2;
   endtask

   task automatic push_stream(input logic [15:0] start, input int n);
      logic [15:0] p;
      p = start;
      for (int i = 0; i < n; i++) begin
         sb.push_back(p);
         p = p + 16'd2;
      end
   endtask

   // Memory: line becomes valid two cycles after the address last changed.
   always @(posedge inp_clk) begin
      #1;
      if (!inp_rst_n || out_mem_address != mem_last) begin
         mem_last = out_mem_address;
         mem_age  = 0;
      end else if (mem_age < 15) begin
         mem_age++;
      end
      inp_mem_valid = (mem_age >= 2);
      for (int k = 0; k < 4; k++)
         inp_mem_dataLine[16*k +: 16] = instr_of(mem_last + 16'(2*k));
   end

   always @(negedge inp_clk) begin
      if (inp_rst_n && !inp_branch_valid && out_instr_valid && inp_instr_ready) begin
         check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_pc = sb.pop_front();
            check("pop_pc", {16'b0, out_pc}, {16'b0, mon_pc});
            check("pop_instr", {16'b0, out_instr}, {16'b0, instr_of(mon_pc)});
            pops++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;

      repeat (3) tick();
      check("rst_valid", {31'b0, out_instr_valid}, 32'd0);
      check("rst_instr", {16'b0, out_instr}, 32'd0);
      check("rst_pc", {16'b0, out_pc}, 32'd0);
      check("rst_busy", {31'b0, out_busy}, 32'd0);
      check("rst_addr", {16'b0, out_mem_address}, 32'd256);

      inp_rst_n = 1'b1;
      n = 0;
      while (!out_instr_valid && n < 20) begin
         tick();
         n++;
      end
      check("t1_first_latency", n, 32'd3);
      check("t1_first_pc", {16'b0, out_pc}, 32'd256);
      check("t1_first_instr", {16'b0, out_instr}, {16'b0, instr_of(16'd256)});
      check("t1_addr_next", {16'b0, out_mem_address}, 32'd264);

      // Decode stalled: FIFO fills and fetch parks on the second line.
      repeat (20) tick();
      check("t2_addr_hold", {16'b0, out_mem_address}, 32'd264);
      check("t2_idle", {31'b0, out_busy}, 32'd0);
      check("t2_valid", {31'b0, out_instr_valid}, 32'd1);
      check("t2_head_pc", {16'b0, out_pc}, 32'd256);

      push_stream(16'd256, 64);
      inp_instr_ready = 1'b1;
      repeat (40) tick();
      check("t1_stream_pops", {31'b0, pops >= 30}, 32'd1);

      // Redirect while a line is being returned.
      n = 0;
      while (!(out_busy && inp_mem_valid) && n < 50) begin
         tick();
         n++;
      end
      check("t3_in_wait", {31'b0, out_busy && inp_mem_valid}, 32'd1);
      inp_branch_target = 16'h0106;
      inp_branch_valid  = 1'b1;
      sb.delete();
      tick();
      inp_branch_valid = 1'b0;
      check("t3_addr", {16'b0, out_mem_address}, 32'h0100);
      check("t3_flushed", {31'b0, out_instr_valid}, 32'd0);
      push_stream(16'h0106, 64);
      p0 = pops;
      repeat (12) tick();
      check("t3_delivered", {31'b0, pops > p0}, 32'd1);

      // Redirect coinciding with a decode pop.
      n = 0;
      while (!out_instr_valid && n < 20) begin
         tick();
         n++;
      end
      check("t4_pop_pending", {31'b0, out_instr_valid}, 32'd1);
      inp_branch_target = 16'h0100;
      inp_branch_valid  = 1'b1;
      sb.delete();
      tick();
      inp_branch_valid = 1'b0;
      check("t4_flushed", {31'b0, out_instr_valid}, 32'd0);
      check("t4_addr", {16'b0, out_mem_address}, 32'h0100);
      push_stream(16'h0100, 64);
      p0 = pops;
      repeat (12) tick();
      check("t4_delivered", {31'b0, pops > p0}, 32'd1);

      // Address wrap at the top of memory.
      inp_branch_target = 16'hFFFC;
      inp_branch_valid  = 1'b1;
      sb.delete();
      tick();
      inp_branch_valid = 1'b0;
      check("t5_addr_top", {16'b0, out_mem_address}, 32'hFFF8);
      push_stream(16'hFFFC, 64);
      n = 0;
      while (out_mem_address == 16'hFFF8 && n < 20) begin
         tick();
         n++;
      end
      check("t5_addr_wrap", {16'b0, out_mem_address}, 32'h0000);
      p0 = pops;
      repeat (12) tick();
      check("t5_delivered", {31'b0, pops >= p0 + 4}, 32'd1);

      // Asynchronous reset in the middle of a wait.
      n = 0;
      while (!(out_busy && inp_mem_valid) && n < 50) begin
         tick();
         n++;
      end
      check("t6_in_wait", {31'b0, out_busy && inp_mem_valid}, 32'd1);
      #1;
      inp_rst_n = 1'b0;
      #1;
      check("t6_valid", {31'b0, out_instr_valid}, 32'd0);
      check("t6_instr", {16'b0, out_instr}, 32'd0);
      check("t6_pc", {16'b0, out_pc}, 32'd0);
      check("t6_busy", {31'b0, out_busy}, 32'd0);
      check("t6_addr", {16'b0, out_mem_address}, 32'd256);
      sb.delete();
      tick();
      tick();
      inp_rst_n = 1'b1;
      push_stream(16'd256, 64);
      p0 = pops;
      repeat (30) tick();
      check("t6_restart", {31'b0, pops > p0}, 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
